// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side sequencer for the UART serial path.
// Accepts bytes over a valid/ready handshake, generates baud timing and
// drives load/start/shift plus the parallel word of an external
// (DATA_W+1)-bit PISO shifter whose serial output is the TX line.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD != 0) ahead of the stop bit.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              piso_load,
  output logic              piso_start,
  output logic              piso_shift,
  output logic [DATA_W:0]   piso_data
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam int NSHIFT = DATA_W + 2;
`else
  localparam int NSHIFT = DATA_W + 1;
`endif
  localparam logic [3:0] NSHIFT_C = 4'(NSHIFT);

  typedef enum logic [2:0] {
    INIT_LD = 3'd0,
    INIT_SH = 3'd1,
    IDLE    = 3'd2,
    LOAD    = 3'd3,
    START   = 3'd4,
    BITS    = 3'd5
  } state_t;

  // Parity of the data byte, inverted for odd parity.
  function automatic logic parity_f(input logic [DATA_W-1:0] data);
    parity_f = (^data) ^ (PARITY_ODD != 0);
  endfunction

  state_t              state_r, state_s;
  logic [BAUD_W-1:0]   baud_r, baud_s;
  logic [3:0]          shcnt_r, shcnt_s;
  logic [DATA_W:0]     piso_data_r, piso_data_s;
  logic                piso_load_r, piso_load_s;
  logic                piso_start_r, piso_start_s;
  logic                piso_shift_r, piso_shift_s;
  logic                tx_ready_r, tx_ready_s;
  logic                tx_busy_r, tx_busy_s;
  logic                tx_done_r, tx_done_s;
  logic                top_bit_s;
  logic                bit_end_s;

  // Bit placed above the data in the shifter word: parity or the stop bit.
  always_comb begin
`ifdef UART_TX_PARITY_EN
    top_bit_s = parity_f(tx_data);
`else
    top_bit_s = 1'b1;
`endif
  end

  // Next state, counters and next-cycle output values (outputs are registered,
  // so they are decoded from the state the FSM is about to enter).
  always_comb begin
    state_s     = state_r;
    baud_s      = baud_r;
    shcnt_s     = shcnt_r;
    piso_data_s = piso_data_r;
    case (state_r)
      INIT_LD: begin
        // Stay one visible cycle with load high before moving on.
        piso_data_s = {(DATA_W+1){1'b1}};
        if (piso_load_r) begin
          state_s = INIT_SH;
        end else begin
          state_s = INIT_LD;
        end
      end
      INIT_SH: state_s = IDLE;
      IDLE: begin
        if (tx_valid && tx_ready_r) begin
          state_s     = LOAD;
          piso_data_s = {top_bit_s, tx_data};
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = START;
      START: begin
        state_s = BITS;
        baud_s  = '0;
        shcnt_s = 4'd0;
      end
      BITS: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (shcnt_r == NSHIFT_C) begin
            state_s = IDLE;
          end else begin
            shcnt_s = shcnt_r + 4'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: state_s = INIT_LD;
    endcase

    bit_end_s    = (state_s == BITS) && (baud_s == BAUD_LAST);
    piso_load_s  = (state_s == INIT_LD) || (state_s == LOAD);
    piso_start_s = (state_s == START);
    piso_shift_s = (state_s == INIT_SH) || (bit_end_s && (shcnt_s != NSHIFT_C));
    tx_ready_s   = (state_s == IDLE);
    tx_busy_s    = (state_s == LOAD) || (state_s == START) || (state_s == BITS);
    tx_done_s    = bit_end_s && (shcnt_s == NSHIFT_C);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= INIT_LD;
      baud_r       <= '0;
      shcnt_r      <= 4'd0;
      piso_data_r  <= '0;
      piso_load_r  <= 1'b0;
      piso_start_r <= 1'b0;
      piso_shift_r <= 1'b0;
      tx_ready_r   <= 1'b0;
      tx_busy_r    <= 1'b0;
      tx_done_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      shcnt_r      <= shcnt_s;
      piso_data_r  <= piso_data_s;
      piso_load_r  <= piso_load_s;
      piso_start_r <= piso_start_s;
      piso_shift_r <= piso_shift_s;
      tx_ready_r   <= tx_ready_s;
      tx_busy_r    <= tx_busy_s;
      tx_done_r    <= tx_done_s;
    end
  end

  assign piso_data  = piso_data_r;
  assign piso_load  = piso_load_r;
  assign piso_start = piso_start_r;
  assign piso_shift = piso_shift_r;
  assign tx_ready   = tx_ready_r;
  assign tx_busy    = tx_busy_r;
  assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural 9-bit PISO on the
// controller outputs. Frames are scoreboarded from the accept cycle.
module tb_uart_tx_ctrl;

  localparam int C    = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NSH = 10;
`else
  localparam int NSH = 9;
`endif
  localparam int FRAME    = NSH + 1;
  localparam int DONE_REL = 2 + FRAME * C;

  typedef struct {
    logic [7:0] data;
    logic       p;
    int         t;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done;
  logic       piso_load, piso_start, piso_shift;
  logic [8:0] piso_data;

  logic [8:0] sh_reg = 9'h000;
  logic       line   = 1'b0;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  bit         line_chk_en = 1'b0;
  exp_t       sbq[$];
  exp_t       me;
  int         rel;
  vec_t       vecs[6];

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .piso_load(piso_load), .piso_start(piso_start), .piso_shift(piso_shift),
    .piso_data(piso_data)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge is the current cycle number.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PISO shifter: fills with ones from the MSB.
  always @(posedge clk) begin
    if (piso_load) sh_reg <= piso_data;
    else if (piso_start) line <= 1'b0;
    else if (piso_shift) begin
      line   <= sh_reg[0];
      sh_reg <= {1'b1, sh_reg[8:1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic frame_bit(input exp_t e, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return e.data[idx-1];
`ifdef UART_TX_PARITY_EN
    else if (idx == 9) return e.p;
`endif
    else return 1'b1;
  endfunction

  function automatic logic [8:0] exp_word(input exp_t e);
`ifdef UART_TX_PARITY_EN
    return {e.p, e.data};
`else
    return {1'b1, e.data};
`endif
  endfunction

  // Monitor: compares controls, line and done timing against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse_onehot", 32'($countones({piso_load, piso_start, piso_shift}) <= 1), 32'd1);
      if (sbq.size() != 0) begin
        me  = sbq[0];
        rel = cyc - me.t;
        if (rel <= 2 && line_chk_en) chk("pre_start_line", 32'(line), 32'd1);
        if (rel == 1) begin
          chk("load_pulse", 32'(piso_load), 32'd1);
          chk("load_word", 32'(piso_data), 32'(exp_word(me)));
        end
        if (rel == 2) chk("start_pulse", 32'(piso_start), 32'd1);
        if (rel >= 1 && rel <= DONE_REL) begin
          chk("ready_low", 32'(tx_ready), 32'd0);
          chk("busy_high", 32'(tx_busy), 32'd1);
        end
        if (rel >= 3 && rel <= DONE_REL) begin
          chk("line_bit", 32'(line), 32'(frame_bit(me, (rel - 3) / C)));
          chk("shift_timing", 32'(piso_shift),
              32'(((rel - 2) % C == 0) && ((rel - 2) / C <= NSH)));
        end
        if (rel >= 1 && rel < DONE_REL) chk("early_done", 32'(tx_done), 32'd0);
        if (rel == DONE_REL) begin
          chk("done_pulse", 32'(tx_done), 32'd1);
          void'(sbq.pop_front());
        end
      end else begin
        chk("spurious_done", 32'(tx_done), 32'd0);
        if (line_chk_en) chk("idle_line", 32'(line), 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one byte; on accept push its expected frame to the scoreboard.
  task automatic send(input logic [7:0] d, input logic par_even, input bit hold, output int t_acc);
    bit got = 1'b0;
    t_acc    = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    if (got) begin
      t_acc = cyc;
      sbq.push_back('{d, par_even ^ PODD[0], cyc});
      step();
      if (!hold) tx_valid = 1'b0;
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_timeout", 32'(ok), 32'd1);
  endtask

  // Release reset at a posedge+2 and check the INIT sequence.
  task automatic release_and_check_init();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load", 32'(piso_load), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    chk("init_load", 32'(piso_load), 32'd1);
    chk("init_data", 32'(piso_data), 32'h1FF);
    chk("init_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    chk("init_shift", 32'(piso_shift), 32'd1);
    chk("init_noload", 32'(piso_load), 32'd0);
    @(negedge clk);
    chk("init_line", 32'(line), 32'd1);
    chk("init_ready_up", 32'(tx_ready), 32'd1);
    line_chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_pulse", 32'({piso_load, piso_start, piso_shift}), 32'd0);
      chk("idle_ready", 32'(tx_ready), 32'd1);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1};

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({tx_ready, tx_busy, tx_done, piso_load, piso_start, piso_shift}), 32'd0);
    chk("reset_data", 32'(piso_data), 32'd0);
    step();
    release_and_check_init();

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].par_even, 1'b0, t1);
      wait_idle(200);
      @(negedge clk);
      chk("after_ready", 32'(tx_ready), 32'd1);
      chk("after_busy", 32'(tx_busy), 32'd0);
      step();
    end

    // Back-to-back with tx_valid held high
    send(8'hA3, 1'b0, 1'b1, t1);
    send(8'h3C, 1'b0, 1'b0, t2);
    chk("b2b_accept_cycle", 32'(t2), 32'(t1 + DONE_REL + 1));
    wait_idle(200);
    step();

    // Inputs wiggle mid-frame: no extra accept, frame unchanged
    send(8'h96, 1'b0, 1'b0, t1);
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    wait_idle(200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_extra_load", 32'(piso_load), 32'd0);
    end
    step();

    // Reset during D3 (0xE5 has D3 = 0)
    send(8'hE5, 1'b1, 1'b0, t1);
    while (cyc < t1 + 3 + 4 * C + 1) @(posedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    line_chk_en = 1'b0;
    step();
    step();
    release_and_check_init();
    send(8'h5A, 1'b0, 1'b0, t1);
    wait_idle(200);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
